// File: rtl/fetch_pkg.sv
// Shared types and constants for the dual-issue fetch controller.
//   NOP_INSTR    : filler for an empty head and for slot 2 at the last ROM word
//   fq_entry_t   : one fetch-queue entry {instr1, instr2, pc, valid2}
//   fetch_state_t: RUN / HOLD / FLUSH
//   pc_advance   : next fetch PC, wrapping the 12-bit PC field
package fetch_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned ROM_AW = 10;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr1;
    logic [XLEN-1:0] instr2;
    logic [XLEN-1:0] pc;
    logic            valid2;
  } fq_entry_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  // Word 1023 has no partner word, so its pair carries only one instruction.
  function automatic logic is_last_word(input logic [ROM_AW-1:0] word);
    return word == '1;
  endfunction

  // Step one pair forward; the 12-bit field wraps and bits above it are carried.
  function automatic logic [XLEN-1:0] pc_advance(input logic [XLEN-1:0] pc);
    logic [11:0] lo;
    lo = is_last_word(pc[11:2]) ? 12'h000 : pc[11:0] + 12'd8;
    return {pc[XLEN-1:12], lo};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Bus bundle between the fetch controller, the dual-issue ROM and decode.
//   rom_addr            : word index to the ROM
//   rom_instr1/2        : ROM words at rom_addr and rom_addr+1 (one cycle later)
//   redirect_valid/_pc  : branch/jump redirect request and target
//   out_ready           : decode accepts the head pair
//   out_valid/_valid2   : head pair present / slot 2 valid
//   out_instr1/2, out_pc: head pair and byte PC of slot 1
// master = fetch controller side, slave = ROM/decode/branch side.
interface fetch_if;
  import fetch_pkg::*;

  logic [ROM_AW-1:0] rom_addr;
  logic [XLEN-1:0]   rom_instr1;
  logic [XLEN-1:0]   rom_instr2;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              out_ready;
  logic              out_valid;
  logic              out_valid2;
  logic [XLEN-1:0]   out_instr1;
  logic [XLEN-1:0]   out_instr2;
  logic [XLEN-1:0]   out_pc;

  modport master (
    output rom_addr,
    input  rom_instr1,
    input  rom_instr2,
    input  redirect_valid,
    input  redirect_pc,
    input  out_ready,
    output out_valid,
    output out_valid2,
    output out_instr1,
    output out_instr2,
    output out_pc
  );

  modport slave (
    input  rom_addr,
    output rom_instr1,
    output rom_instr2,
    output redirect_valid,
    output redirect_pc,
    output out_ready,
    input  out_valid,
    input  out_valid2,
    input  out_instr1,
    input  out_instr2,
    input  out_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Fetch queue: circular buffer of fq_entry_t with synchronous flush.
//   clk, rst    : clock, synchronous active-high reset
//   flush_i     : empty the queue (wins over push and pop)
//   push_i      : write push_data_i at the tail (dropped when full)
//   pop_i       : retire the head (ignored when empty)
//   head_o      : current head entry (meaningful only when !empty_o)
//   count_o     : number of valid entries
//   empty_o     : queue empty
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  fq_entry_t        push_data_i,
  input  logic             pop_i,
  output fq_entry_t        head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fq_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = count_q == CNT_W'(DEPTH);
  assign empty_o = count_q == '0;
  assign do_push = push_i && !full;
  assign do_pop  = pop_i && !empty_o;

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Entry storage; contents need no reset because count_q qualifies them.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Dual-issue instruction fetch controller.
// Issues one ROM pair fetch per cycle while the queue has credit, captures the
// ROM response one cycle later into the fetch queue, and presents the queue
// head to decode. Redirects flush the queue and the in-flight response.
//   clk, rst       : clock, synchronous active-high reset
//   bus (master)   : ROM address/data, redirect request, decode handshake
//   perf_hold_cnt  : cycles spent in HOLD           (FETCH_PERF_EN only)
//   perf_flush_cnt : redirects taken                (FETCH_PERF_EN only)
// Optional feature macro: FETCH_PERF_EN adds the saturating perf counters.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     FQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  fetch_if.master     bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_hold_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(FQ_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  fetch_state_t     state_q;
  fetch_state_t     state_d;
  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  pc_d;
  logic             inflight_q;
  logic [XLEN-1:0]  inflight_pc_q;
  logic             inflight_last_q;

  logic             redirect;
  logic             credit;
  logic             issue;
  logic             push;
  logic             pop;
  logic [OCC_W-1:0] occupancy;

  logic [CNT_W-1:0] fq_count;
  logic             fq_empty;
  fq_entry_t        fq_head;
  fq_entry_t        push_data;

  assign redirect = bus.redirect_valid;

  // Credit counts the in-flight response but not a same-cycle pop.
  assign occupancy = OCC_W'(fq_count) + OCC_W'(inflight_q);
  assign credit    = occupancy < OCC_W'(FQ_DEPTH);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // FSM next state: redirect always wins; otherwise credit picks RUN or HOLD.
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = FLUSH;
    end else begin
      case (state_q)
        RUN, FLUSH, HOLD: state_d = credit ? RUN : HOLD;
        default:          state_d = RUN;
      endcase
    end
  end

  // FSM output: HOLD never issues, even on the cycle credit returns.
  always_comb begin
    issue = 1'b0;
    case (state_q)
      RUN, FLUSH: issue = !redirect && credit;
      default:    issue = 1'b0;
    endcase
  end

  // PC next value.
  always_comb begin
    pc_d = pc_q;
    if (redirect)   pc_d = bus.redirect_pc;
    else if (issue) pc_d = pc_advance(pc_q);
  end

  // PC and in-flight tracking; the in-flight slot lives exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q            <= RESET_PC;
      inflight_q      <= 1'b0;
      inflight_pc_q   <= RESET_PC;
      inflight_last_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q   <= pc_q;
        inflight_last_q <= is_last_word(pc_q[11:2]);
      end
    end
  end

  assign bus.rom_addr = pc_q[11:2];

  // ROM response capture; a redirect in the same cycle discards it.
  assign push             = inflight_q && !redirect;
  assign push_data.instr1 = bus.rom_instr1;
  assign push_data.instr2 = inflight_last_q ? NOP_INSTR : bus.rom_instr2;
  assign push_data.pc     = inflight_pc_q;
  assign push_data.valid2 = !inflight_last_q;

  assign pop = !fq_empty && bus.out_ready;

  fetch_fifo #(
    .DEPTH (FQ_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (redirect),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (fq_head),
    .count_o     (fq_count),
    .empty_o     (fq_empty)
  );

  // Head presentation; an empty queue shows NOPs at RESET_PC.
  assign bus.out_valid  = !fq_empty;
  assign bus.out_valid2 = !fq_empty && fq_head.valid2;
  assign bus.out_instr1 = fq_empty ? NOP_INSTR : fq_head.instr1;
  assign bus.out_instr2 = fq_empty ? NOP_INSTR : fq_head.instr2;
  assign bus.out_pc     = fq_empty ? RESET_PC  : fq_head.pc;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_hold_q;
  logic [31:0] perf_flush_q;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_hold_q  <= '0;
      perf_flush_q <= '0;
    end else begin
      if (state_q == HOLD && perf_hold_q != '1) perf_hold_q  <= perf_hold_q + 32'd1;
      if (redirect && perf_flush_q != '1)       perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_hold_cnt  = perf_hold_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenario tasks plus a scoreboard
// that predicts the pair stream from each reset/redirect target.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned FQ_DEPTH = 4;
  localparam int unsigned STREAM_LEN = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   hs_cnt = 0;

  logic [31:0] rom [1024];
  fq_entry_t   exp_q [$];

  fetch_if bus();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_hold_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  fetch_ctrl #(
    .RESET_PC (RESET_PC),
    .FQ_DEPTH (FQ_DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_hold_cnt  (perf_hold_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Dual-issue ROM with one cycle of read latency.
  always @(posedge clk) begin
    logic [9:0] a2;
    a2 = bus.rom_addr + 10'd1;
    bus.rom_instr1 <= rom[bus.rom_addr];
    bus.rom_instr2 <= rom[a2];
  end

  // Reference model of the pair fetched at a given PC.
  function automatic fq_entry_t model_entry(input logic [31:0] pc);
    fq_entry_t e;
    logic [9:0] w;
    logic [9:0] w2;
    w  = pc[11:2];
    w2 = w + 10'd1;
    e.instr1 = rom[w];
    e.pc     = pc;
    if (w == 10'd1023) begin
      e.instr2 = 32'h0000_0013;
      e.valid2 = 1'b0;
    end else begin
      e.instr2 = rom[w2];
      e.valid2 = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] pc);
    logic [11:0] lo;
    if (pc[11:2] == 10'd1023) lo = 12'h000;
    else                      lo = pc[11:0] + 12'd8;
    return {pc[31:12], lo};
  endfunction

  task automatic load_stream(input logic [31:0] start);
    logic [31:0] pc;
    exp_q.delete();
    pc = start;
    for (int i = 0; i < int'(STREAM_LEN); i++) begin
      exp_q.push_back(model_entry(pc));
      pc = model_next(pc);
    end
  endtask

  // Scoreboard: reload on reset/redirect, compare every accepted head pair.
  always @(negedge clk) begin
    fq_entry_t got;
    fq_entry_t want;
    if (rst) begin
      load_stream(RESET_PC);
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        hs_cnt++;
        vectors++;
        got.instr1 = bus.out_instr1;
        got.instr2 = bus.out_instr2;
        got.pc     = bus.out_pc;
        got.valid2 = bus.out_valid2;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL scoreboard_underflow: got pc=%h, required no pair", got.pc);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            miscompares++;
            $display("FAIL scoreboard_pair: got pc=%h i1=%h i2=%h v2=%b, required pc=%h i1=%h i2=%h v2=%b",
                     got.pc, got.instr1, got.instr2, got.valid2,
                     want.pc, want.instr1, want.instr2, want.valid2);
          end
        end
      end
      if (bus.redirect_valid) load_stream(bus.redirect_pc);
    end
  end

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic to_sample();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.out_ready = 1'b0;
    repeat (3) to_drive();
    to_sample();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.out_valid2 !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid2: got %b want 0", bus.out_valid2); end
    vectors++; if (bus.out_instr1 !== 32'h13) begin miscompares++; $display("FAIL rst_out_instr1: got %h want 00000013", bus.out_instr1); end
    vectors++; if (bus.out_instr2 !== 32'h13) begin miscompares++; $display("FAIL rst_out_instr2: got %h want 00000013", bus.out_instr2); end
    vectors++; if (bus.out_pc !== RESET_PC) begin miscompares++; $display("FAIL rst_out_pc: got %h want %h", bus.out_pc, RESET_PC); end
    to_drive();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      to_sample();
      vectors++;
      if (bus.rom_addr !== 10'(2 * k)) begin
        miscompares++; $display("FAIL rst_rom_addr[%0d]: got %0d want %0d", k, bus.rom_addr, 2 * k);
      end
      vectors++;
      if (bus.out_valid !== (k == 2)) begin
        miscompares++; $display("FAIL rst_first_valid[%0d]: got %b want %b", k, bus.out_valid, (k == 2));
      end
    end
    vectors++; if (bus.out_pc !== 32'h0) begin miscompares++; $display("FAIL rst_first_pc: got %h want 0", bus.out_pc); end
    vectors++; if (bus.out_instr1 !== rom[0]) begin miscompares++; $display("FAIL rst_first_i1: got %h want %h", bus.out_instr1, rom[0]); end
    vectors++; if (bus.out_instr2 !== rom[1]) begin miscompares++; $display("FAIL rst_first_i2: got %h want %h", bus.out_instr2, rom[1]); end
  endtask

  task automatic test_backpressure();
    int h0;
    repeat (20) to_sample();
    vectors++; if (dut.fq_count !== 3'd4) begin miscompares++; $display("FAIL bp_count: got %0d want 4", dut.fq_count); end
    vectors++; if (dut.state_q !== HOLD) begin miscompares++; $display("FAIL bp_state: got %0d want HOLD", dut.state_q); end
    vectors++; if (bus.rom_addr !== 10'd8) begin miscompares++; $display("FAIL bp_rom_addr: got %0d want 8", bus.rom_addr); end
    vectors++; if (bus.out_pc !== 32'h0) begin miscompares++; $display("FAIL bp_head_pc: got %h want 0", bus.out_pc); end
    to_drive();
    bus.out_ready = 1'b1;
    h0 = hs_cnt;
    repeat (12) to_sample();
    vectors++;
    if (hs_cnt - h0 < 10) begin miscompares++; $display("FAIL bp_drain: got %0d pairs want >= 10", hs_cnt - h0); end
    to_drive();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_redirect();
    to_drive();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h20;
    to_drive();
    bus.redirect_valid = 1'b0;
    repeat (4) to_drive();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    to_sample();
    vectors++; if (dut.fq_count !== 3'd3) begin miscompares++; $display("FAIL redir_pre_count: got %0d want 3", dut.fq_count); end
    vectors++; if (dut.inflight_q !== 1'b1) begin miscompares++; $display("FAIL redir_pre_inflight: got %b want 1", dut.inflight_q); end
    to_drive();
    bus.redirect_valid = 1'b0;
    to_sample();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL redir_flushed: got %b want 0", bus.out_valid); end
    vectors++; if (dut.fq_count !== 3'd0) begin miscompares++; $display("FAIL redir_count: got %0d want 0", dut.fq_count); end
    to_sample();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL redir_stale: got %b want 0", bus.out_valid); end
    to_sample();
    vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL redir_valid: got %b want 1", bus.out_valid); end
    vectors++; if (bus.out_pc !== 32'h100) begin miscompares++; $display("FAIL redir_pc: got %h want 00000100", bus.out_pc); end
    vectors++; if (bus.out_instr1 !== rom[64]) begin miscompares++; $display("FAIL redir_i1: got %h want %h", bus.out_instr1, rom[64]); end
    to_drive();
    bus.out_ready = 1'b1;
    repeat (5) to_drive();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    to_drive();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFC;
    to_drive();
    bus.redirect_valid = 1'b0;
    to_sample();
    vectors++; if (bus.rom_addr !== 10'd1023) begin miscompares++; $display("FAIL wrap_addr_last: got %0d want 1023", bus.rom_addr); end
    to_sample();
    vectors++; if (bus.rom_addr !== 10'd0) begin miscompares++; $display("FAIL wrap_addr_zero: got %0d want 0", bus.rom_addr); end
    to_sample();
    vectors++; if (bus.out_pc !== 32'hFFC) begin miscompares++; $display("FAIL wrap_pc: got %h want 00000ffc", bus.out_pc); end
    vectors++; if (bus.out_valid2 !== 1'b0) begin miscompares++; $display("FAIL wrap_valid2: got %b want 0", bus.out_valid2); end
    vectors++; if (bus.out_instr2 !== 32'h13) begin miscompares++; $display("FAIL wrap_nop: got %h want 00000013", bus.out_instr2); end
    vectors++; if (bus.out_instr1 !== rom[1023]) begin miscompares++; $display("FAIL wrap_i1: got %h want %h", bus.out_instr1, rom[1023]); end
    to_drive();
    bus.out_ready = 1'b1;
    to_drive();
    bus.out_ready = 1'b0;
    to_sample();
    vectors++; if (bus.out_pc !== 32'h0) begin miscompares++; $display("FAIL wrap_next_pc: got %h want 0", bus.out_pc); end
    vectors++; if (bus.out_valid2 !== 1'b1) begin miscompares++; $display("FAIL wrap_next_valid2: got %b want 1", bus.out_valid2); end
  endtask

  task automatic test_reset_midstream();
    to_drive();
    bus.out_ready = 1'b1;
    repeat (6) to_drive();
    rst = 1'b1;
    to_sample();
    vectors++; if (dut.inflight_q !== 1'b1) begin miscompares++; $display("FAIL mid_pre_inflight: got %b want 1", dut.inflight_q); end
    to_drive();
    rst = 1'b0;
    to_sample();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_out_valid: got %b want 0", bus.out_valid); end
    vectors++; if (dut.inflight_q !== 1'b0) begin miscompares++; $display("FAIL mid_inflight: got %b want 0", dut.inflight_q); end
    vectors++; if (bus.rom_addr !== RESET_PC[11:2]) begin miscompares++; $display("FAIL mid_rom_addr: got %0d want %0d", bus.rom_addr, RESET_PC[11:2]); end
    to_sample();
    vectors++; if (bus.rom_addr !== 10'd2) begin miscompares++; $display("FAIL mid_rom_addr2: got %0d want 2", bus.rom_addr); end
    to_sample();
    vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL mid_restart_valid: got %b want 1", bus.out_valid); end
    vectors++; if (bus.out_pc !== RESET_PC) begin miscompares++; $display("FAIL mid_restart_pc: got %h want %h", bus.out_pc, RESET_PC); end
  endtask

  task automatic test_back_to_back();
    int h0;
    to_drive();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    to_drive();
    bus.redirect_pc    = 32'h80;
    to_drive();
    bus.redirect_valid = 1'b0;
    to_sample();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_empty0: got %b want 0", bus.out_valid); end
    to_sample();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_empty1: got %b want 0", bus.out_valid); end
    to_sample();
    vectors++; if (bus.out_pc !== 32'h80) begin miscompares++; $display("FAIL b2b_first_pc: got %h want 00000080", bus.out_pc); end
    h0 = hs_cnt;
    repeat (6) to_sample();
    vectors++; if (hs_cnt - h0 < 4) begin miscompares++; $display("FAIL b2b_stream: got %0d pairs want >= 4", hs_cnt - h0); end
`ifdef FETCH_PERF_EN
    vectors++; if (perf_flush_cnt !== 32'd2) begin miscompares++; $display("FAIL b2b_perf_flush: got %0d want 2", perf_flush_cnt); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = {12'(i), 5'd0, 3'd0, 5'd1, 7'h13};
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.out_ready      = 1'b0;
    test_reset();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_reset_midstream();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

endmodule
